branch_pc_unit: RTL and testbench
=================================

Name: branch_pc_unit

Overview:
- Sequential next-PC stage directly downstream of the 32-bit comparator in the single-cycle RV32I core.
- Consumes the comparator's signed and unsigned less-than results and the equality result, plus decode controls.
- Resolves conditional branches, JAL and JALR, and owns the architectural PC register.
- Traps on misaligned targets and keeps saturating branch statistics counters for debug/performance readout.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded when a misaligned-target trap fires.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold all state this cycle.
- branch  input  1  current instruction is B-type.
- jal  input  1  current instruction is JAL.
- jalr  input  1  current instruction is JALR.
- funct3  input  3  B-type condition select.
- a_lt_b  input  1  signed rs1 < rs2, from the comparator.
- a_ltu_b  input  1  unsigned rs1 < rs2.
- a_eq_b  input  1  rs1 == rs2.
- imm  input  32  sign-extended immediate.
- rs1_data  input  32  rs1 value, used by JALR.
- pc  output  32  current PC (registered).
- pc_plus4  output  32  pc + 4, the link value (combinational).
- taken  output  1  redirect decision this cycle (combinational).
- trap  output  1  misaligned-target trap pulse (registered, 1 cycle).
- epc  output  32  PC of the trapping instruction (registered).
- br_cnt  output  CNT_W  number of conditional branches retired.
- tk_cnt  output  CNT_W  number of conditional branches taken.

Behaviour:
- Reset (asynchronous, any time, including mid-stall) sets:
  - pc = RESET_PC
  - trap = 0
  - epc = 0
  - br_cnt = 0
  - tk_cnt = 0
- Condition decode when branch = 1, by funct3:
  - 000: take if a_eq_b.
  - 001: take if !a_eq_b.
  - 100: take if a_lt_b.
  - 101: take if !a_lt_b.
  - 110: take if a_ltu_b.
  - 111: take if !a_ltu_b.
  - 010 or 011: never taken. These still count in br_cnt.
- Control priority when more than one control is high: jalr > jal > branch. Only the winning control applies.
- taken:
  - Equals 1 for jal or jalr.
  - Equals the decoded condition for branch.
  - Equals 0 otherwise.
  - Combinational, and independent of stall.
- Target address (all arithmetic 32-bit, wraps modulo 2^32):
  - jal or branch: pc + imm.
  - jalr: (rs1_data + imm) with bit 0 cleared.
- Misaligned: taken = 1 and target[1:0] != 0. For JALR this check is made after bit 0 is cleared, so only bit 1 can trigger it.
- Next state when stall = 0, evaluated in this order:
  - misaligned: pc <= TRAP_VEC, epc <= pc, trap <= 1.
  - else if taken: pc <= target, trap <= 0.
  - else: pc <= pc + 4 (wraps from FFFF_FFFC to 0000_0000), trap <= 0.
- Counters update only when branch is the winning control and stall = 0:
  - br_cnt increments by 1.
  - tk_cnt increments by 1 if the condition is taken and the target is not misaligned.
  - Both saturate at 2^CNT_W - 1 and never wrap.
- When stall = 1:
  - pc, epc and both counters hold.
  - trap <= 0.
  - taken still reflects the inputs.
- trap is high for exactly one cycle per trapping instruction.
- Latency: a redirect is visible on pc on the clock edge after the instruction is presented (one cycle). Single-cycle core, so there is no flush.

Test Plan:
- Reset release with no controls for 3 cycles -> pc = 0, 4, 8, 0xC; all counters 0; trap 0.
- pc = 0x40, branch = 1, funct3 = 000, a_eq_b = 1, imm = 0x20 -> taken = 1; next pc = 0x60; br_cnt = 1; tk_cnt = 1. Repeat with funct3 = 101 and a_lt_b = 1 -> not taken; next pc = 0x64; br_cnt = 2; tk_cnt = 1.
- pc = 0x80, jalr = 1, rs1_data = 0x1003, imm = 0 -> target 0x1002 is misaligned -> trap = 1 for one cycle; epc = 0x80; pc = 0x100. Same case with rs1_data = 0x1001 -> pc = 0x1000, no trap.
- jal = 1, imm = 0xFFFF_FFF8 at pc = 0x10 -> pc = 0x08. Separately, pc = 0xFFFF_FFFC with no controls -> pc wraps to 0x0.
- stall = 1 during a taken BEQ for 3 cycles -> pc, epc and counters unchanged; taken = 1 throughout. Assert rst mid-stall -> immediate asynchronous clear to RESET_PC.
- CNT_W = 2: issue 5 taken branches -> br_cnt and tk_cnt saturate at 3. Assert jal and branch together -> JAL target used; counters unchanged.

Source files
------------

// File: rtl/branch_pc_unit.sv
// Next-PC stage for the single-cycle RV32I core: branch/JAL/JALR resolve, misaligned trap, branch stats.
// Redirect lands on pc one edge after presentation; stall freezes pc/epc/counters and drops trap.
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch,
    input  logic             jal,
    input  logic             jalr,
    input  logic [2:0]       funct3,
    input  logic             a_lt_b,
    input  logic             a_ltu_b,
    input  logic             a_eq_b,
    input  logic [31:0]      imm,
    input  logic [31:0]      rs1_data,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             taken,
    output logic             trap,
    output logic [31:0]      epc,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] tk_cnt
);

    typedef struct packed {
        logic jalr;
        logic jal;
        logic br;
    } sel_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      epc_q, epc_d;
    logic             trap_q, trap_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] tk_cnt_q, tk_cnt_d;

    sel_t        sel;
    logic        cond;
    logic [31:0] jalr_sum;
    logic [31:0] target;
    logic        misaligned;

    // Only the highest-priority control is allowed to act.
    always_comb begin
        sel      = '0;
        sel.jalr = jalr;
        sel.jal  = jal & ~jalr;
        sel.br   = branch & ~jal & ~jalr;
    end

    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = a_eq_b;
            3'b001:  cond = ~a_eq_b;
            3'b100:  cond = a_lt_b;
            3'b101:  cond = ~a_lt_b;
            3'b110:  cond = a_ltu_b;
            3'b111:  cond = ~a_ltu_b;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        jalr_sum   = rs1_data + imm;
        taken      = sel.jalr | sel.jal | (sel.br & cond);
        target     = sel.jalr ? {jalr_sum[31:1], 1'b0} : (pc_q + imm);
        misaligned = taken & (target[1:0] != 2'b00);
    end

    always_comb begin
        pc_d     = pc_q;
        epc_d    = epc_q;
        trap_d   = 1'b0;
        br_cnt_d = br_cnt_q;
        tk_cnt_d = tk_cnt_q;
        if (!stall) begin
            if (misaligned) begin
                pc_d   = TRAP_VEC;
                epc_d  = pc_q;
                trap_d = 1'b1;
            end else if (taken) begin
                pc_d = target;
            end else begin
                pc_d = pc_q + 32'd4;
            end
            if (sel.br) begin
                if (br_cnt_q != CNT_MAX) begin
                    br_cnt_d = br_cnt_q + CNT_ONE;
                end
                // A taken branch that traps did not actually redirect.
                if (cond && !misaligned && tk_cnt_q != CNT_MAX) begin
                    tk_cnt_d = tk_cnt_q + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            epc_q    <= 32'h0;
            trap_q   <= 1'b0;
            br_cnt_q <= '0;
            tk_cnt_q <= '0;
        end else begin
            pc_q     <= pc_d;
            epc_q    <= epc_d;
            trap_q   <= trap_d;
            br_cnt_q <= br_cnt_d;
            tk_cnt_q <= tk_cnt_d;
        end
    end

    always_comb begin
        pc       = pc_q;
        pc_plus4 = pc_q + 32'd4;
        trap     = trap_q;
        epc      = epc_q;
        br_cnt   = br_cnt_q;
        tk_cnt   = tk_cnt_q;
    end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: one default instance plus a CNT_W=2 instance for saturation.
module tb_branch_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall, branch, jal, jalr;
    logic [2:0]  funct3;
    logic        a_lt_b, a_ltu_b, a_eq_b;
    logic [31:0] imm, rs1_data;

    logic [31:0] pc, pc_plus4, epc;
    logic        taken, trap;
    logic [15:0] br_cnt, tk_cnt;

    logic [31:0] s_pc, s_pc_plus4, s_epc;
    logic        s_taken, s_trap;
    logic [1:0]  s_br_cnt, s_tk_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] exp_pc;
    int          exp_br, exp_tk;

    typedef struct packed {
        logic [2:0] f3;
        logic       eq;
        logic       lt;
        logic       ltu;
        logic       tk;
    } bvec_t;

    bvec_t tbl [11];

    branch_pc_unit u_dut (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .jal(jal), .jalr(jalr),
        .funct3(funct3), .a_lt_b(a_lt_b), .a_ltu_b(a_ltu_b), .a_eq_b(a_eq_b),
        .imm(imm), .rs1_data(rs1_data), .pc(pc), .pc_plus4(pc_plus4), .taken(taken),
        .trap(trap), .epc(epc), .br_cnt(br_cnt), .tk_cnt(tk_cnt)
    );

    branch_pc_unit #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .jal(jal), .jalr(jalr),
        .funct3(funct3), .a_lt_b(a_lt_b), .a_ltu_b(a_ltu_b), .a_eq_b(a_eq_b),
        .imm(imm), .rs1_data(rs1_data), .pc(s_pc), .pc_plus4(s_pc_plus4), .taken(s_taken),
        .trap(s_trap), .epc(s_epc), .br_cnt(s_br_cnt), .tk_cnt(s_tk_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        stall = 1'b0; branch = 1'b0; jal = 1'b0; jalr = 1'b0;
        funct3 = 3'b000; a_lt_b = 1'b0; a_ltu_b = 1'b0; a_eq_b = 1'b0;
        imm = 32'h0; rs1_data = 32'h0;
    endtask

    task automatic do_jal(input logic [31:0] off);
        idle();
        jal = 1'b1; imm = off;
        @(negedge clk);
        idle();
    endtask

    initial begin
        tbl[0]  = '{3'b001, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{3'b001, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{3'b100, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{3'b100, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{3'b101, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{3'b110, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{3'b110, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{3'b111, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{3'b111, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{3'b010, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{3'b011, 1'b1, 1'b1, 1'b1, 1'b0};

        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_trap", {31'b0, trap}, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_br", {16'b0, br_cnt}, 32'h0);
        chk("rst_tk", {16'b0, tk_cnt}, 32'h0);
        rst = 1'b0;
        #1 chk("pc_0", pc, 32'h0);
        @(negedge clk); chk("pc_4", pc, 32'h4);
        @(negedge clk); chk("pc_8", pc, 32'h8);
        @(negedge clk); chk("pc_c", pc, 32'hC);
        chk("pc_plus4", pc_plus4, 32'h10);
        chk("idle_taken", {31'b0, taken}, 32'h0);

        do_jal(32'h34);
        chk("jal_to_40", pc, 32'h40);

        branch = 1'b1; funct3 = 3'b000; a_eq_b = 1'b1; imm = 32'h20;
        #1 chk("beq_taken", {31'b0, taken}, 32'h1);
        @(negedge clk);
        chk("beq_pc", pc, 32'h60);
        chk("beq_br", {16'b0, br_cnt}, 32'd1);
        chk("beq_tk", {16'b0, tk_cnt}, 32'd1);

        idle();
        branch = 1'b1; funct3 = 3'b101; a_lt_b = 1'b1; imm = 32'h20;
        #1 chk("bge_taken", {31'b0, taken}, 32'h0);
        @(negedge clk);
        chk("bge_pc", pc, 32'h64);
        chk("bge_br", {16'b0, br_cnt}, 32'd2);
        chk("bge_tk", {16'b0, tk_cnt}, 32'd1);

        do_jal(32'h1C);
        chk("jal_to_80", pc, 32'h80);

        jalr = 1'b1; rs1_data = 32'h1003; imm = 32'h0;
        @(negedge clk);
        idle();
        chk("jalr_mis_trap", {31'b0, trap}, 32'h1);
        chk("jalr_mis_epc", epc, 32'h80);
        chk("jalr_mis_pc", pc, 32'h100);
        @(negedge clk);
        chk("trap_pulse", {31'b0, trap}, 32'h0);
        chk("after_trap_pc", pc, 32'h104);

        jalr = 1'b1; rs1_data = 32'h1001; imm = 32'h0;
        @(negedge clk);
        idle();
        chk("jalr_bit0_pc", pc, 32'h1000);
        chk("jalr_bit0_trap", {31'b0, trap}, 32'h0);

        do_jal(32'hFFFF_F010);
        chk("jal_to_10", pc, 32'h10);
        do_jal(32'hFFFF_FFF8);
        chk("jal_neg", pc, 32'h08);

        jalr = 1'b1; rs1_data = 32'hFFFF_FFFC;
        @(negedge clk);
        idle();
        chk("pc_top", pc, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("pc_wrap", pc, 32'h0);

        exp_pc = 32'h0; exp_br = 2; exp_tk = 1;
        for (int i = 0; i < 11; i++) begin
            idle();
            branch = 1'b1; funct3 = tbl[i].f3; a_eq_b = tbl[i].eq;
            a_lt_b = tbl[i].lt; a_ltu_b = tbl[i].ltu; imm = 32'h8;
            #1 chk($sformatf("tbl%0d_taken", i), {31'b0, taken}, {31'b0, tbl[i].tk});
            exp_pc = tbl[i].tk ? exp_pc + 32'd8 : exp_pc + 32'd4;
            exp_br++;
            if (tbl[i].tk) exp_tk++;
            @(negedge clk);
            chk($sformatf("tbl%0d_pc", i), pc, exp_pc);
        end
        idle();
        chk("tbl_br", {16'b0, br_cnt}, exp_br);
        chk("tbl_tk", {16'b0, tk_cnt}, exp_tk);

        // Taken branch to a halfword target traps and is not counted as taken.
        branch = 1'b1; funct3 = 3'b000; a_eq_b = 1'b1; imm = 32'h2;
        @(negedge clk);
        chk("br_mis_trap", {31'b0, trap}, 32'h1);
        chk("br_mis_pc", pc, 32'h100);
        chk("br_mis_epc", epc, exp_pc);
        chk("br_mis_br", {16'b0, br_cnt}, exp_br + 1);
        chk("br_mis_tk", {16'b0, tk_cnt}, exp_tk);

        idle();
        stall = 1'b1; branch = 1'b1; funct3 = 3'b000; a_eq_b = 1'b1; imm = 32'h20;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_taken", {31'b0, taken}, 32'h1);
            @(negedge clk);
            chk("stall_trap", {31'b0, trap}, 32'h0);
            chk("stall_pc", pc, 32'h100);
            chk("stall_epc", epc, exp_pc);
            chk("stall_br", {16'b0, br_cnt}, exp_br + 1);
            chk("stall_tk", {16'b0, tk_cnt}, exp_tk);
        end
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_epc", epc, 32'h0);
        chk("async_rst_br", {16'b0, br_cnt}, 32'h0);
        chk("async_rst_tk", {16'b0, tk_cnt}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle();

        for (int i = 0; i < 5; i++) begin
            branch = 1'b1; funct3 = 3'b000; a_eq_b = 1'b1; imm = 32'h8;
            @(negedge clk);
        end
        idle();
        chk("sat_pc", s_pc, 32'h28);
        chk("sat_br", {30'b0, s_br_cnt}, 32'd3);
        chk("sat_tk", {30'b0, s_tk_cnt}, 32'd3);
        chk("wide_br", {16'b0, br_cnt}, 32'd5);
        chk("wide_tk", {16'b0, tk_cnt}, 32'd5);

        jal = 1'b1; branch = 1'b1; funct3 = 3'b000; a_eq_b = 1'b0; imm = 32'h40;
        #1 chk("jal_br_taken", {31'b0, taken}, 32'h1);
        @(negedge clk);
        idle();
        chk("jal_br_pc", pc, 32'h68);
        chk("jal_br_br", {16'b0, br_cnt}, 32'd5);
        chk("jal_br_tk", {16'b0, tk_cnt}, 32'd5);
        chk("jal_br_sat_br", {30'b0, s_br_cnt}, 32'd3);

        jalr = 1'b1; jal = 1'b1; rs1_data = 32'h200; imm = 32'h0;
        @(negedge clk);
        idle();
        chk("jalr_over_jal", pc, 32'h200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
